// File: rtl/vga_fb_scan_if.sv
// Framebuffer read port and video output bundle for the VGA framebuffer scanner.
// fb_rd/fb_addr form a request with no backpressure; fb_data must be valid exactly RD_LAT clocks after it.
interface vga_fb_scan_if #(
    parameter int ADDR_W = 15
);
    logic              fb_rd;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_data;
    logic              hsync;
    logic              vsync;
    logic              sync_b;
    logic              blank_b;
    logic [7:0]        r;
    logic [7:0]        g;
    logic [7:0]        b;
    logic              frame_start;

    modport master (
        output fb_rd, fb_addr, hsync, vsync, sync_b, blank_b, r, g, b, frame_start,
        input  fb_data
    );

    modport slave (
        input  fb_rd, fb_addr, hsync, vsync, sync_b, blank_b, r, g, b, frame_start,
        output fb_data
    );
endinterface

// File: rtl/vga_fb_scan.sv
// VGA timing generator that scans an integer-upscaled greyscale framebuffer
// through a fixed-latency read port and emits fully registered video.
module vga_fb_scan #(
    parameter int         H_ACTIVE   = 640,
    parameter int         H_FP       = 16,
    parameter int         H_SYNC     = 96,
    parameter int         H_BP       = 48,
    parameter int         V_ACTIVE   = 480,
    parameter int         V_FP       = 10,
    parameter int         V_SYNC     = 2,
    parameter int         V_BP       = 33,
    parameter int         SYNC_POL   = 0,
    parameter int         FB_W       = 160,
    parameter int         FB_H       = 120,
    parameter int         SCALE_LOG2 = 2,
    parameter int         RD_LAT     = 2,
    parameter logic [7:0] BORDER     = 8'h20
) (
    input logic           vgaclk,
    input logic           reset_b,
    vga_fb_scan_if.master bus
);
    localparam int HTOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VTOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW     = $clog2(HTOT);
    localparam int VW     = $clog2(VTOT);
    localparam int ADDR_W = $clog2(FB_W * FB_H);
    // The image window is clipped to the visible area up front.
    localparam int WIN_W  = ((FB_W << SCALE_LOG2) < H_ACTIVE) ? (FB_W << SCALE_LOG2) : H_ACTIVE;
    localparam int WIN_H  = ((FB_H << SCALE_LOG2) < V_ACTIVE) ? (FB_H << SCALE_LOG2) : V_ACTIVE;
    localparam int ROW_LIM = (((FB_H - 1) << SCALE_LOG2) < (VTOT - 1)) ?
                             ((FB_H - 1) << SCALE_LOG2) : (VTOT - 1);

    localparam logic [HW-1:0]     H_LAST   = HW'(HTOT - 1);
    localparam logic [HW-1:0]     H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0]     H_WIN_C  = HW'(WIN_W);
    localparam logic [HW-1:0]     HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]     HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]     V_LAST   = VW'(VTOT - 1);
    localparam logic [VW-1:0]     V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0]     V_WIN_C  = VW'(WIN_H);
    localparam logic [VW-1:0]     VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]     VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0]     V_SUB    = VW'((1 << SCALE_LOG2) - 1);
    localparam logic [VW-1:0]     ROW_STOP = VW'(ROW_LIM);
    localparam logic [ADDR_W-1:0] FB_W_C   = ADDR_W'(FB_W);
    localparam logic              POL      = (SYNC_POL != 0);

    typedef struct packed {
        logic active;
        logic window;
        logic hs;
        logic vs;
        logic first;
    } ctl_t;

    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col;
    logic              h_wrap;
    logic              v_wrap;
    logic              row_step;
    ctl_t              ctl_now;
    ctl_t              pipe [RD_LAT];
    ctl_t              tail;
    logic              hsync_q;
    logic              vsync_q;
    logic              sync_b_q;
    logic              blank_q;
    logic              fs_q;
    logic [7:0]        pix_q;

    assign h_wrap   = (hcnt == H_LAST);
    assign v_wrap   = (vcnt == V_LAST);
    // Row base advances after the last line of each upscaled source row.
    assign row_step = ((vcnt & V_SUB) == V_SUB) && (vcnt < ROW_STOP);

    always_ff @(posedge vgaclk or negedge reset_b) begin
        if (!reset_b) begin
            hcnt     <= '0;
            vcnt     <= '0;
            row_base <= '0;
        end else begin
            hcnt <= h_wrap ? '0 : hcnt + HW'(1);
            if (h_wrap) begin
                if (v_wrap) begin
                    vcnt     <= '0;
                    row_base <= '0;
                end else begin
                    vcnt <= vcnt + VW'(1);
                    if (row_step) begin
                        row_base <= row_base + FB_W_C;
                    end
                end
            end
        end
    end

    always_comb begin
        ctl_now        = '0;
        ctl_now.active = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
        ctl_now.window = (hcnt < H_WIN_C) && (vcnt < V_WIN_C);
        ctl_now.hs     = (hcnt >= HS_BEG) && (hcnt < HS_END);
        ctl_now.vs     = (vcnt >= VS_BEG) && (vcnt < VS_END);
        ctl_now.first  = (hcnt == '0) && (vcnt == '0);
    end

    assign col         = ADDR_W'(hcnt >> SCALE_LOG2);
    assign bus.fb_rd   = ctl_now.window;
    assign bus.fb_addr = ctl_now.window ? (row_base + col) : '0;

    // Control delay line keeps timing flags aligned with the returning read data.
    always_ff @(posedge vgaclk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= ctl_now;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail = pipe[RD_LAT-1];

    always_ff @(posedge vgaclk or negedge reset_b) begin
        if (!reset_b) begin
            hsync_q  <= ~POL;
            vsync_q  <= ~POL;
            sync_b_q <= 1'b1;
            blank_q  <= 1'b0;
            fs_q     <= 1'b0;
            pix_q    <= 8'h00;
        end else begin
            hsync_q  <= tail.hs ? POL : ~POL;
            vsync_q  <= tail.vs ? POL : ~POL;
            sync_b_q <= ~(tail.hs | tail.vs);
            blank_q  <= tail.active;
            fs_q     <= tail.first;
            pix_q    <= tail.window ? bus.fb_data : (tail.active ? BORDER : 8'h00);
        end
    end

    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.sync_b      = sync_b_q;
    assign bus.blank_b     = blank_q;
    assign bus.frame_start = fs_q;
    assign bus.r           = pix_q;
    assign bus.g           = pix_q;
    assign bus.b           = pix_q;
endmodule

// File: tb/tb_vga_fb_scan.sv
// Directed bench for vga_fb_scan on a shrunk 24x16 raster: instance A (latency 2,
// active-low sync, bordered window) and instance B (latency 4, active-high sync, clipped window).
module tb_vga_fb_scan;
    localparam int HTOT = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   edges;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   cnt_on = 1'b0;
    int   hs_a = 0, vs_a = 0, sb_a = 0, bl_a = 0, fs_a = 0, bd_a = 0;
    int   hs_b = 0, vs_b = 0, sb_b = 0, bl_b = 0, fs_b = 0, bd_b = 0;

    always #5 clk = ~clk;

    vga_fb_scan_if #(.ADDR_W(3)) bus_a ();
    vga_fb_scan_if #(.ADDR_W(5)) bus_b ();

    vga_fb_scan #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .FB_W(3), .FB_H(2), .SCALE_LOG2(1), .RD_LAT(2), .BORDER(8'h20)
    ) dut_a (.vgaclk(clk), .reset_b(rst_n), .bus(bus_a));

    vga_fb_scan #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1), .FB_W(5), .FB_H(4), .SCALE_LOG2(2), .RD_LAT(4), .BORDER(8'h20)
    ) dut_b (.vgaclk(clk), .reset_b(rst_n), .bus(bus_b));

    // Framebuffer models: pixel = 0x80 + address, returned after the read latency.
    logic [7:0] mem_a [2];
    logic [7:0] mem_b [4];
    always @(posedge clk) begin
        mem_a[0] <= 8'h80 + {5'b0, bus_a.fb_addr};
        mem_a[1] <= mem_a[0];
        mem_b[0] <= 8'h80 + {3'b0, bus_b.fb_addr};
        for (int i = 1; i < 4; i++) mem_b[i] <= mem_b[i-1];
    end
    assign bus_a.fb_data = mem_a[1];
    assign bus_b.fb_data = mem_b[3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // One-frame output tallies after the first release.
    always @(negedge clk) begin
        if (cnt_on && edges >= 3 && edges < 3 + 384) begin
            if (!bus_a.hsync) hs_a++;
            if (!bus_a.vsync) vs_a++;
            if (!bus_a.sync_b) sb_a++;
            if (bus_a.blank_b) bl_a++;
            if (bus_a.frame_start) fs_a++;
            if (bus_a.blank_b && bus_a.r == 8'h20) bd_a++;
        end
        if (cnt_on && edges >= 5 && edges < 5 + 384) begin
            if (bus_b.hsync) hs_b++;
            if (bus_b.vsync) vs_b++;
            if (!bus_b.sync_b) sb_b++;
            if (bus_b.blank_b) bl_b++;
            if (bus_b.frame_start) fs_b++;
            if (bus_b.blank_b && bus_b.r == 8'h20) bd_b++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_edge(input int k);
        while (edges < k) @(negedge clk);
    endtask

    task automatic reset_vals(input string t);
        check({t, " A hsync"}, 32'(bus_a.hsync), 1);
        check({t, " A vsync"}, 32'(bus_a.vsync), 1);
        check({t, " B hsync"}, 32'(bus_b.hsync), 0);
        check({t, " B vsync"}, 32'(bus_b.vsync), 0);
        check({t, " A sync_b"}, 32'(bus_a.sync_b), 1);
        check({t, " B sync_b"}, 32'(bus_b.sync_b), 1);
        check({t, " A blank_b"}, 32'(bus_a.blank_b), 0);
        check({t, " B blank_b"}, 32'(bus_b.blank_b), 0);
        check({t, " A rgb"}, {8'h0, bus_a.r, bus_a.g, bus_a.b}, 0);
        check({t, " B rgb"}, {8'h0, bus_b.r, bus_b.g, bus_b.b}, 0);
        check({t, " A frame_start"}, 32'(bus_a.frame_start), 0);
        check({t, " B frame_start"}, 32'(bus_b.frame_start), 0);
        check({t, " A fb_rd"}, 32'(bus_a.fb_rd), 1);
        check({t, " B fb_rd"}, 32'(bus_b.fb_rd), 1);
        check({t, " A fb_addr"}, 32'(bus_a.fb_addr), 0);
        check({t, " B fb_addr"}, 32'(bus_b.fb_addr), 0);
    endtask

    // Output sample for raster position (x,y); hs/vs are the expected pin levels.
    task automatic out_pt(input bit sel, input int x, input int y, input int pix,
                          input int bl, input int hs, input int vs, input int fs);
        string t;
        int    sb;
        wait_edge(y * HTOT + x + (sel ? 5 : 3));
        t  = $sformatf("%s(%0d,%0d)", sel ? "B" : "A", x, y);
        sb = sel ? (((hs | vs) == 0) ? 1 : 0) : (hs & vs);
        if (!sel) begin
            check({t, " r"}, 32'(bus_a.r), pix);
            check({t, " g"}, 32'(bus_a.g), pix);
            check({t, " b"}, 32'(bus_a.b), pix);
            check({t, " blank_b"}, 32'(bus_a.blank_b), bl);
            check({t, " hsync"}, 32'(bus_a.hsync), hs);
            check({t, " vsync"}, 32'(bus_a.vsync), vs);
            check({t, " sync_b"}, 32'(bus_a.sync_b), sb);
            check({t, " frame_start"}, 32'(bus_a.frame_start), fs);
        end else begin
            check({t, " r"}, 32'(bus_b.r), pix);
            check({t, " g"}, 32'(bus_b.g), pix);
            check({t, " b"}, 32'(bus_b.b), pix);
            check({t, " blank_b"}, 32'(bus_b.blank_b), bl);
            check({t, " hsync"}, 32'(bus_b.hsync), hs);
            check({t, " vsync"}, 32'(bus_b.vsync), vs);
            check({t, " sync_b"}, 32'(bus_b.sync_b), sb);
            check({t, " frame_start"}, 32'(bus_b.frame_start), fs);
        end
    endtask

    // Read-port sample for counter position (x,y): zero latency from the counters.
    task automatic addr_pt(input bit sel, input int x, input int y, input int rd, input int addr);
        string t;
        wait_edge(y * HTOT + x);
        t = $sformatf("%s cnt(%0d,%0d)", sel ? "B" : "A", x, y);
        check({t, " fb_rd"}, sel ? 32'(bus_b.fb_rd) : 32'(bus_a.fb_rd), rd);
        check({t, " fb_addr"}, sel ? 32'(bus_b.fb_addr) : 32'(bus_a.fb_addr), addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_vals("reset");
        cnt_on = 1'b1;
        rst_n  = 1'b1;

        //           sel x   y  pix    bl hs vs fs
        out_pt(0,  0,  0, 'h80, 1, 1, 1, 1);
        out_pt(0,  1,  0, 'h80, 1, 1, 1, 0);
        out_pt(0,  2,  0, 'h81, 1, 1, 1, 0);
        addr_pt(0, 6,  0, 0, 0);
        out_pt(0,  6,  0, 'h20, 1, 1, 1, 0);
        out_pt(0, 15,  0, 'h20, 1, 1, 1, 0);
        out_pt(0, 16,  0, 'h00, 0, 1, 1, 0);
        out_pt(0, 17,  0, 'h00, 0, 1, 1, 0);
        out_pt(0, 18,  0, 'h00, 0, 0, 1, 0);
        out_pt(0, 20,  0, 'h00, 0, 0, 1, 0);
        out_pt(0, 21,  0, 'h00, 0, 1, 1, 0);
        addr_pt(0, 3,  1, 1, 1);
        out_pt(0,  5,  1, 'h82, 1, 1, 1, 0);
        out_pt(0,  0,  2, 'h83, 1, 1, 1, 0);
        addr_pt(0, 4,  2, 1, 5);
        addr_pt(0, 5,  3, 1, 5);
        out_pt(0,  5,  3, 'h85, 1, 1, 1, 0);
        addr_pt(0, 0,  4, 0, 0);
        out_pt(0,  0,  4, 'h20, 1, 1, 1, 0);
        out_pt(0, 15, 11, 'h20, 1, 1, 1, 0);
        out_pt(0,  0, 12, 'h00, 0, 1, 1, 0);
        out_pt(0,  0, 13, 'h00, 0, 1, 0, 0);
        out_pt(0, 19, 14, 'h00, 0, 0, 0, 0);
        out_pt(0, 23, 14, 'h00, 0, 1, 0, 0);
        out_pt(0,  0, 15, 'h00, 0, 1, 1, 0);
        out_pt(0, 23, 15, 'h00, 0, 1, 1, 0);
        out_pt(0,  0, 16, 'h80, 1, 1, 1, 1);

        wait_edge(3 + 384 + 2);
        check("A hsync clocks", hs_a, 48);
        check("A vsync clocks", vs_a, 48);
        check("A sync_b low clocks", sb_a, 90);
        check("A blank_b high clocks", bl_a, 192);
        check("A frame_start pulses", fs_a, 1);
        check("A border pixels", bd_a, 168);
        check("B hsync clocks", hs_b, 48);
        check("B vsync clocks", vs_b, 48);
        check("B sync_b low clocks", sb_b, 90);
        check("B blank_b high clocks", bl_b, 192);
        check("B frame_start pulses", fs_b, 1);
        check("B border pixels", bd_b, 0);

        // Asynchronous reset in the middle of frame 2.
        out_pt(0, 2, 17, 'h81, 1, 1, 1, 0);
        cnt_on = 1'b0;
        #2 rst_n = 1'b0;
        #1 reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        addr_pt(0, 0, 0, 1, 0);
        addr_pt(1, 0, 0, 1, 0);
        wait_edge(2);
        check("A frame_start early", 32'(bus_a.frame_start), 0);
        out_pt(0,  0,  0, 'h80, 1, 1, 1, 1);

        addr_pt(1, 4,  0, 1, 1);
        out_pt(1,  0,  0, 'h80, 1, 0, 0, 1);
        out_pt(1,  3,  0, 'h80, 1, 0, 0, 0);
        out_pt(1,  4,  0, 'h81, 1, 0, 0, 0);
        addr_pt(1, 16, 0, 0, 0);
        out_pt(1, 15,  0, 'h83, 1, 0, 0, 0);
        out_pt(1, 16,  0, 'h00, 0, 0, 0, 0);
        out_pt(1, 17,  0, 'h00, 0, 0, 0, 0);
        out_pt(1, 18,  0, 'h00, 0, 1, 0, 0);
        out_pt(1, 20,  0, 'h00, 0, 1, 0, 0);
        out_pt(1, 21,  0, 'h00, 0, 0, 0, 0);
        out_pt(1, 15,  3, 'h83, 1, 0, 0, 0);
        out_pt(1,  0,  4, 'h85, 1, 0, 0, 0);
        addr_pt(1, 15, 11, 1, 13);
        out_pt(1, 15, 11, 'h8d, 1, 0, 0, 0);
        addr_pt(1, 0, 12, 0, 0);
        out_pt(1,  0, 12, 'h00, 0, 0, 0, 0);
        out_pt(1,  0, 13, 'h00, 0, 0, 1, 0);
        out_pt(1, 18, 13, 'h00, 0, 1, 1, 0);
        out_pt(1,  0, 15, 'h00, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vga_fb_scan.md
VGA_FB_SCAN -- requirements
Module: vga_fb_scan

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync lengths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync lengths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0, sync level during sync pulse (0 = active low).
REQ-006 SHALL have parameters FB_W/FB_H, defaults 160/120, framebuffer width and height in pixels.
REQ-007 SHALL have parameter SCALE_LOG2, default 2, upscale factor 2^SCALE_LOG2 in both axes.
REQ-008 SHALL have parameter RD_LAT, default 2, framebuffer read latency in clocks (>=1).
REQ-009 SHALL have parameter BORDER, default 8'h20, grey level for active pixels outside the image window.
REQ-010 SHALL have: vgaclk  in  1  pixel clock, sole clock.
REQ-011 SHALL have: reset_b  in  1  asynchronous, active-low reset.
REQ-012 SHALL have: fb_rd  out  1  framebuffer read strobe.
REQ-013 SHALL have: fb_addr  out  clog2(FB_W*FB_H)  framebuffer read address.
REQ-014 SHALL have: fb_data  in  8  grey pixel, valid RD_LAT clocks after fb_rd/fb_addr.
REQ-015 SHALL have: hsync, vsync  out  1 each  sync outputs at SYNC_POL.
REQ-016 SHALL have: sync_b  out  1  composite sync, low when either sync is asserted.
REQ-017 SHALL have: blank_b  out  1  high during the active display area.
REQ-018 SHALL have: r, g, b  out  8 each  pixel colour.
REQ-019 SHALL have: frame_start  out  1  one-clock pulse coincident with output pixel (0,0).

Function
REQ-020 hcnt SHALL count 0..HTOT-1, HTOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800), then wrap to 0.
REQ-021 vcnt SHALL increment only on the hcnt wrap, counting 0..VTOT-1 (525), then wrap to 0; both wraps occur in the same clock at frame end.
REQ-022 Line order SHALL be active, front porch, sync, back porch; hsync asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751 by default.
REQ-023 vsync SHALL be asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491, on whole lines.
REQ-024 active = hcnt<H_ACTIVE and vcnt<V_ACTIVE; window = active and hcnt<(FB_W<<SCALE_LOG2) and vcnt<(FB_H<<SCALE_LOG2); a window larger than the active area SHALL be clipped.
REQ-025 fb_rd SHALL equal window for the current counter state (combinational from counter registers, zero latency).
REQ-026 fb_addr SHALL equal (vcnt>>SCALE_LOG2)*FB_W + (hcnt>>SCALE_LOG2) when fb_rd=1 and hold 0 otherwise; no hardware multiplier: a row-base register adds FB_W every 2^SCALE_LOG2 lines and clears at vcnt wrap.
REQ-027 All of hsync, vsync, sync_b, blank_b, r/g/b, frame_start SHALL be registered and correspond to the counter state RD_LAT+1 clocks earlier (delay-line pipeline of active, window, syncs, frame flag).
REQ-028 Output colour SHALL be r=g=b=fb_data if delayed window, BORDER if delayed active and not window, 0 otherwise.
REQ-029 frame_start SHALL pulse exactly once per VTOT*HTOT clocks (420000 by default).
REQ-030 Each fb_addr value SHALL be presented for exactly 2^SCALE_LOG2 consecutive clocks within a line and repeated on 2^SCALE_LOG2 consecutive lines.

Reset
REQ-031 While reset_b=0: hcnt=vcnt=0, row base=0, all pipeline stages cleared; hsync=vsync=~SYNC_POL, sync_b=1, blank_b=0, r=g=b=0, frame_start=0.
REQ-032 fb_rd/fb_addr SHALL follow the counters during reset (window true at (0,0), so fb_rd=1, fb_addr=0).
REQ-033 Reset asserted mid-frame SHALL take effect asynchronously; after release the first frame SHALL start at (0,0) with frame_start at clock RD_LAT+1 after the first vgaclk edge.

Verification
REQ-034 Defaults, release reset -> frame_start at clock 3, again 420000 clocks later; hsync low for 96 clocks per 800; vsync low for 1600 clocks per frame.
REQ-035 fb_data = low byte of fb_addr modelled with 2-cycle latency -> output row 0 reads 0,0,0,0,1,1,1,1,...159 for x=0..639; output rows 0..3 identical; row 4 starts at 160.
REQ-036 FB_W=100, FB_H=50, SCALE_LOG2=1 -> blank_b=1 for 640 clocks per active line; pixels 200..639 of lines 0..99 and all of lines 100..479 equal BORDER; blanking 0.
REQ-037 RD_LAT=4 -> every output delayed 5 clocks from counter state; hsync falls 5 clocks after hcnt=656.
REQ-038 reset_b pulsed low at hcnt=300, vcnt=200 -> outputs immediately at reset values; after release fb_addr=0, frame_start at clock 3.
REQ-039 SYNC_POL=1 -> hsync/vsync high during sync, low otherwise; sync_b still low during either sync.
